// File: rtl/feature_wdma_gen.sv
// rtl/feature_wdma_gen.sv - feature-map write DMA: pixel stream to MCIF burst write requests
// Walks width (bursts), height (rows by line stride) and channel groups (by surface stride).
// Each burst is one command word followed by cmd_len+1 data beats on the same request channel.
// Optional build macro WDMA_PERF_CNT_EN enables the request stall-cycle counter.
module feature_wdma_gen #(
    parameter int TOUT      = 32,
    parameter int DAT_DW    = 8,
    parameter int BURST_LEN = 16,
    parameter int W_BITS    = 12,
    parameter int H_BITS    = 12,
    parameter int CH_BITS   = 12,
    parameter int ADDR_W    = 32
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start,
    input  logic [W_BITS-1:0]                                 w_m1,
    input  logic [H_BITS-1:0]                                 h_m1,
    input  logic [CH_BITS-1:0]                                ch_groups,
    input  logic [ADDR_W-1:0]                                 base_addr,
    input  logic [ADDR_W-1:0]                                 surface_stride,
    input  logic [ADDR_W-1:0]                                 line_stride,
    input  logic                                              dat_in_vld,
    input  logic [TOUT*DAT_DW-1:0]                            dat_in_pd,
    output logic                                              dat_in_rdy,
    output logic                                              wr_req_vld,
    input  logic                                              wr_req_rdy,
    output logic [2+$clog2(BURST_LEN)+ADDR_W+TOUT*DAT_DW-1:0] wr_req_pd,
    input  logic                                              wr_rsp_complete,
    output logic                                              busy,
    output logic                                              done,
    output logic [31:0]                                       perf_stall_cnt
);

    localparam int LBL  = $clog2(BURST_LEN);
    localparam int DW   = TOUT * DAT_DW;
    localparam int PD_W = 2 + LBL + ADDR_W + DW;
    localparam int BPP  = DW / 8;
    // Byte distance between consecutive bursts of one row.
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BPP);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        DATA     = 2'd2,
        WAIT_RSP = 2'd3
    } state_t;

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;

    // Configuration captured at start so the caller may change inputs mid-run.
    logic [W_BITS-1:0]    w_m1_q;
    logic [H_BITS-1:0]    h_m1_q;
    logic [CH_BITS-1:0]   ch_groups_q;
    logic [ADDR_W-1:0]    base_addr_q;
    logic [ADDR_W-1:0]    surface_stride_q;
    logic [ADDR_W-1:0]    line_stride_q;

    // Loop position and the incrementally accumulated byte offsets.
    logic [LBL-1:0]       beat_cnt_q;
    logic [W_BITS-1:0]    burst_idx_q, burst_idx_d;
    logic [H_BITS-1:0]    row_q, row_d;
    logic [CH_BITS-1:0]   chg_q, chg_d;
    logic [ADDR_W-1:0]    chg_base_q, chg_base_d;
    logic [ADDR_W-1:0]    row_base_q, row_base_d;
    logic [ADDR_W-1:0]    cur_off_q, cur_off_d;

    logic                 burst_last;
    logic                 row_last;
    logic                 chg_last;
    logic                 final_burst;
    logic [LBL-1:0]       cmd_len;
    logic                 beat_last;
    logic                 data_hs;
    logic [PD_W-1:0]      cmd_word;
    logic [PD_W-1:0]      data_word;

    assign burst_last  = (burst_idx_q == (w_m1_q >> LBL));
    assign row_last    = (row_q == h_m1_q);
    assign chg_last    = (chg_q == (ch_groups_q - CH_BITS'(1)));
    assign final_burst = burst_last && row_last && chg_last;
    // Only the tail burst of a row can be short; all others run the full burst length.
    assign cmd_len     = burst_last ? w_m1_q[LBL-1:0] : LBL'(BURST_LEN - 1);
    assign beat_last   = (beat_cnt_q == cmd_len);
    assign data_hs     = (state_q == DATA) && dat_in_vld && wr_req_rdy;

    assign cmd_word  = {1'b1, {(DW-ADDR_W){1'b0}}, base_addr_q, final_burst, cmd_len, cur_off_q};
    assign data_word = {{(PD_W-DW){1'b0}}, dat_in_pd};

    // Next loop position once the current burst has finished: step width, then row, then channel group.
    always_comb begin
        burst_idx_d = burst_idx_q + W_BITS'(1);
        row_d       = row_q;
        chg_d       = chg_q;
        chg_base_d  = chg_base_q;
        row_base_d  = row_base_q;
        cur_off_d   = cur_off_q + BURST_BYTES;
        if (burst_last) begin
            burst_idx_d = '0;
            if (!row_last) begin
                row_d      = row_q + H_BITS'(1);
                row_base_d = row_base_q + line_stride_q;
                cur_off_d  = row_base_d;
            end else begin
                row_d      = '0;
                chg_d      = chg_q + CH_BITS'(1);
                chg_base_d = chg_base_q + surface_stride_q;
                row_base_d = chg_base_d;
                cur_off_d  = chg_base_d;
            end
        end
    end

    // Main sequencer: command/data alternation per burst, then wait for write retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            w_m1_q           <= '0;
            h_m1_q           <= '0;
            ch_groups_q      <= '0;
            base_addr_q      <= '0;
            surface_stride_q <= '0;
            line_stride_q    <= '0;
            beat_cnt_q       <= '0;
            burst_idx_q      <= '0;
            row_q            <= '0;
            chg_q            <= '0;
            chg_base_q       <= '0;
            row_base_q       <= '0;
            cur_off_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        w_m1_q           <= w_m1;
                        h_m1_q           <= h_m1;
                        ch_groups_q      <= ch_groups;
                        base_addr_q      <= base_addr;
                        surface_stride_q <= surface_stride;
                        line_stride_q    <= line_stride;
                        beat_cnt_q       <= '0;
                        burst_idx_q      <= '0;
                        row_q            <= '0;
                        chg_q            <= '0;
                        chg_base_q       <= '0;
                        row_base_q       <= '0;
                        cur_off_q        <= '0;
                        busy_q           <= 1'b1;
                        state_q          <= CMD;
                    end
                end
                CMD: begin
                    if (wr_req_rdy) begin
                        beat_cnt_q <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (data_hs) begin
                        if (beat_last) begin
                            beat_cnt_q <= '0;
                            if (final_burst) begin
                                state_q <= WAIT_RSP;
                            end else begin
                                burst_idx_q <= burst_idx_d;
                                row_q       <= row_d;
                                chg_q       <= chg_d;
                                chg_base_q  <= chg_base_d;
                                row_base_q  <= row_base_d;
                                cur_off_q   <= cur_off_d;
                                state_q     <= CMD;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + LBL'(1);
                        end
                    end
                end
                WAIT_RSP: begin
                    if (wr_rsp_complete) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data beats pass straight through so MCIF back-pressure reaches the pixel source in the same cycle.
    assign wr_req_vld = (state_q == CMD) || ((state_q == DATA) && dat_in_vld);
    assign dat_in_rdy = (state_q == DATA) && wr_req_rdy;
    assign wr_req_pd  = (state_q == CMD)  ? cmd_word  :
                        (state_q == DATA) ? data_word : '0;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef WDMA_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles where a request is offered but MCIF is not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_cnt_q <= '0;
        end else if (wr_req_vld && !wr_req_rdy && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_feature_wdma_gen.sv
// tb/tb_feature_wdma_gen.sv - scoreboard bench for feature_wdma_gen
module tb_feature_wdma_gen;

    localparam int TOUT = 32;
    localparam int DAT_DW = 8;
    localparam int BL = 16;
    localparam int LBL = 4;
    localparam int AW = 32;
    localparam int DW = TOUT * DAT_DW;
    localparam int PD_W = 2 + LBL + AW + DW;
    localparam int BPP = DW / 8;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [11:0]     w_m1;
    logic [11:0]     h_m1;
    logic [11:0]     ch_groups;
    logic [AW-1:0]   base_addr;
    logic [AW-1:0]   surface_stride;
    logic [AW-1:0]   line_stride;
    logic            dat_in_vld;
    logic [DW-1:0]   dat_in_pd;
    logic            dat_in_rdy;
    logic            wr_req_vld;
    logic            wr_req_rdy;
    logic [PD_W-1:0] wr_req_pd;
    logic            wr_rsp_complete;
    logic            busy;
    logic            done;
    logic [31:0]     perf_stall_cnt;

    feature_wdma_gen #(
        .TOUT(TOUT), .DAT_DW(DAT_DW), .BURST_LEN(BL),
        .W_BITS(12), .H_BITS(12), .CH_BITS(12), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .w_m1(w_m1), .h_m1(h_m1), .ch_groups(ch_groups),
        .base_addr(base_addr), .surface_stride(surface_stride), .line_stride(line_stride),
        .dat_in_vld(dat_in_vld), .dat_in_pd(dat_in_pd), .dat_in_rdy(dat_in_rdy),
        .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_req_pd(wr_req_pd),
        .wr_rsp_complete(wr_rsp_complete), .busy(busy), .done(done),
        .perf_stall_cnt(perf_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    logic [PD_W-1:0] exp_q[$];
    logic [DW-1:0]   src_q[$];
    bit   rand_mode = 0;
    int   stall_cnt = 0;
    int   out_hs_cnt = 0;
    bit   done_seen = 0;
    logic in_hs_s = 1'b0;

    task automatic chk(input string tag, input logic [PD_W-1:0] got, input logic [PD_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [PD_W-1:0] cmd_word(input logic [AW-1:0] base, input bit np,
                                                  input logic [LBL-1:0] len, input logic [AW-1:0] off);
        return {1'b1, {(DW-AW){1'b0}}, base, np, len, off};
    endfunction

    // Reference walk: push command and data words in MCIF order, data words also to the source.
    task automatic plan(input int w, input int h, input int ch, input logic [AW-1:0] base,
                        input logic [AW-1:0] ls, input logic [AW-1:0] ss);
        int nb;
        nb = (w / BL) + 1;
        for (int c = 0; c < ch; c++) begin
            for (int r = 0; r <= h; r++) begin
                for (int b = 0; b < nb; b++) begin
                    bit last;
                    bit np;
                    logic [LBL-1:0] len;
                    logic [AW-1:0] off;
                    last = (b == nb - 1);
                    len  = last ? LBL'(w % BL) : LBL'(BL - 1);
                    np   = last && (r == h) && (c == ch - 1);
                    off  = AW'(b * BL * BPP) + AW'(r) * ls + AW'(c) * ss;
                    exp_q.push_back(cmd_word(base, np, len, off));
                    for (int k = 0; k <= int'(len); k++) begin
                        logic [DW-1:0] d;
                        for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
                        src_q.push_back(d);
                        exp_q.push_back({{(PD_W-DW){1'b0}}, d});
                    end
                end
            end
        end
    endtask

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        in_hs_s = dat_in_vld && dat_in_rdy;
        if (rst_n) begin
            if (wr_req_vld && !wr_req_rdy) stall_cnt++;
            if (!wr_req_rdy) chk("rdy_gate", PD_W'(dat_in_rdy), PD_W'(0));
            if (done) done_seen = 1;
            if (wr_req_vld && wr_req_rdy) begin
                out_hs_cnt++;
                if (exp_q.size() == 0) chk("unexpected_req", PD_W'(exp_q.size()), PD_W'(1));
                else chk("req_pd", wr_req_pd, exp_q.pop_front());
            end
        end
    end

    // Pixel source and MCIF ready driver.
    initial begin
        dat_in_vld = 1'b0;
        dat_in_pd  = '0;
        wr_req_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (in_hs_s && src_q.size() > 0) src_q.delete(0);
            if (src_q.size() > 0) begin
                dat_in_vld = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                dat_in_pd  = src_q[0];
            end else begin
                dat_in_vld = 1'b0;
                dat_in_pd  = '0;
            end
            wr_req_rdy = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic kick(input int w, input int h, input int ch, input logic [AW-1:0] base,
                        input logic [AW-1:0] ls, input logic [AW-1:0] ss);
        w_m1 = 12'(w); h_m1 = 12'(h); ch_groups = 12'(ch);
        base_addr = base; line_stride = ls; surface_stride = ss;
        stall_cnt = 0;
        done_seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_case(input string nm, input int w, input int h, input int ch,
                            input logic [AW-1:0] base, input logic [AW-1:0] ls,
                            input logic [AW-1:0] ss, input bit rnd, input bit poke);
        int cnt;
        plan(w, h, ch, base, ls, ss);
        rand_mode = rnd;
        kick(w, h, ch, base, ls, ss);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 3000) begin
            if (poke) begin
                start = (cnt == 10);
                wr_rsp_complete = (cnt == 10);
            end
            tick();
            cnt++;
        end
        start = 1'b0;
        wr_rsp_complete = 1'b0;
        chk({nm, "_drain"}, PD_W'(exp_q.size()), PD_W'(0));
        chk({nm, "_no_early_done"}, PD_W'(done_seen), PD_W'(0));
        if (poke) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        tick();
        chk({nm, "_wait_busy"}, PD_W'(busy), PD_W'(1));
        chk({nm, "_wait_vld"}, PD_W'(wr_req_vld), PD_W'(0));
        chk({nm, "_wait_done"}, PD_W'(done), PD_W'(0));
`ifdef WDMA_PERF_CNT_EN
        chk({nm, "_stall_cnt"}, PD_W'(perf_stall_cnt), PD_W'(stall_cnt));
`else
        chk({nm, "_stall_cnt"}, PD_W'(perf_stall_cnt), PD_W'(0));
`endif
        wr_rsp_complete = 1'b1;
        tick();
        wr_rsp_complete = 1'b0;
        chk({nm, "_done_pulse"}, PD_W'(done), PD_W'(1));
        chk({nm, "_busy_drop"}, PD_W'(busy), PD_W'(0));
        tick();
        chk({nm, "_done_low"}, PD_W'(done), PD_W'(0));
        chk({nm, "_idle_busy"}, PD_W'(busy), PD_W'(0));
        rand_mode = 0;
        exp_q.delete();
        src_q.delete();
    endtask

    initial begin
        int cnt;
        int base_cnt;
        rst_n = 1'b0;
        start = 1'b0;
        wr_rsp_complete = 1'b0;
        w_m1 = '0; h_m1 = '0; ch_groups = 12'd1;
        base_addr = '0; surface_stride = '0; line_stride = '0;
        repeat (3) tick();
        chk("rst_busy", PD_W'(busy), PD_W'(0));
        chk("rst_done", PD_W'(done), PD_W'(0));
        chk("rst_vld", PD_W'(wr_req_vld), PD_W'(0));
        chk("rst_rdy", PD_W'(dat_in_rdy), PD_W'(0));
        chk("rst_pd", wr_req_pd, '0);
        chk("rst_perf", PD_W'(perf_stall_cnt), PD_W'(0));
        rst_n = 1'b1;
        tick();

        run_case("s1", 15, 0, 1, 32'h1000, 32'h0, 32'h0, 0, 0);
        run_case("s2", 39, 0, 1, 32'h1000, 32'h0, 32'h0, 0, 0);
        run_case("s3", 15, 1, 2, 32'h1000, 32'h2000, 32'h10000, 0, 0);
        run_case("rnd", 39, 0, 1, 32'h4000, 32'h0, 32'h0, 1, 0);
        run_case("wrap", 16, 2, 3, 32'hABCD0000, 32'h300, 32'hFFFF0000, 1, 0);

        // Reset in the middle of the first burst, then a clean rerun.
        plan(15, 0, 1, 32'h1000, 32'h0, 32'h0);
        base_cnt = out_hs_cnt;
        kick(15, 0, 1, 32'h1000, 32'h0, 32'h0);
        cnt = 0;
        while (out_hs_cnt < base_cnt + 6 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("rst_mid_reach", PD_W'(out_hs_cnt - base_cnt), PD_W'(6));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", PD_W'(wr_req_vld), PD_W'(0));
        chk("rst_mid_busy", PD_W'(busy), PD_W'(0));
        chk("rst_mid_done", PD_W'(done), PD_W'(0));
        chk("rst_mid_rdy", PD_W'(dat_in_rdy), PD_W'(0));
        exp_q.delete();
        src_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        run_case("s1_again", 15, 0, 1, 32'h1000, 32'h0, 32'h0, 0, 0);

        run_case("poke", 39, 0, 1, 32'h2000, 32'h0, 32'h0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
